kamacore_data_memory_access: RTL

Memory-stage responder for the load/store control signals carried in the pipeline stage bundle. It takes the stage's memory read/write request, ALU address and rs2 store data, and runs one transaction on the data bus. It formats loads (byte/half/word, signed/unsigned) and returns the load result to the stage. It asserts stall while a transaction is outstanding, and reports misalignment, bus errors and timeouts.

---
 rtl/kamacore_data_memory_access.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/kamacore_data_memory_access.sv
// Memory-stage load/store responder: issues one data-bus transaction per request,
// formats load data and reports misalignment, bus errors and timeouts.
module kamacore_data_memory_access #(
    parameter int CPU_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_read,
    input  logic                 req_write,
    input  logic [2:0]           req_funct3,
    input  logic [CPU_WIDTH-1:0] req_addr,
    input  logic [CPU_WIDTH-1:0] req_wdata,
    output logic                 stall,
    output logic [CPU_WIDTH-1:0] result,
    output logic                 result_valid,
    output logic                 fault,
    output logic [1:0]           fault_cause,
    output logic [CPU_WIDTH-1:0] fault_addr,
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [CPU_WIDTH-1:0] bus_addr,
    output logic [3:0]           bus_be,
    output logic [CPU_WIDTH-1:0] bus_wdata,
    input  logic                 bus_ack,
    input  logic                 bus_err,
    input  logic [CPU_WIDTH-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic                 bus_req_q, bus_req_d;
    logic                 bus_we_q, bus_we_d;
    logic [CPU_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]           bus_be_q, bus_be_d;
    logic [CPU_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic [CPU_WIDTH-1:0] result_q, result_d;
    logic                 result_valid_q, result_valid_d;
    logic                 fault_q, fault_d;
    logic [1:0]           fault_cause_q, fault_cause_d;
    logic [CPU_WIDTH-1:0] fault_addr_q, fault_addr_d;
    logic [2:0]           f3_q, f3_d;
    logic [CPU_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]           cnt_q, cnt_d;

    logic                 req_active;
    logic                 load_ok;
    logic                 store_ok;
    logic                 illegal;
    logic                 misaligned;
    logic [3:0]           be_calc;
    logic [CPU_WIDTH-1:0] wdata_calc;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [CPU_WIDTH-1:0] load_fmt;

    // Request decode
    always_comb begin
        req_active = req_read | req_write;
        load_ok    = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                     (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        store_ok   = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        illegal    = (req_read & req_write) | (req_read & ~load_ok) | (req_write & ~store_ok);
        misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                     ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
        case (req_funct3[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << req_addr[1:0];
                wdata_calc = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{req_wdata[15:0]}};
            end
            default: begin
                be_calc    = 4'b1111;
                wdata_calc = req_wdata;
            end
        endcase
    end

    // Load formatting uses the size code and byte offset captured at issue
    always_comb begin
        case (addr_q[1:0])
            2'b00:   byte_sel = bus_rdata[7:0];
            2'b01:   byte_sel = bus_rdata[15:8];
            2'b10:   byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        half_sel = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_q)
            3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_fmt = {24'd0, byte_sel};
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_fmt = {16'd0, half_sel};
            default: load_fmt = bus_rdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        bus_req_d      = bus_req_q;
        bus_we_d       = bus_we_q;
        bus_addr_d     = bus_addr_q;
        bus_be_d       = bus_be_q;
        bus_wdata_d    = bus_wdata_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        fault_d        = 1'b0;
        fault_cause_d  = fault_cause_q;
        fault_addr_d   = fault_addr_q;
        f3_d           = f3_q;
        addr_d         = addr_q;
        cnt_d          = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_active) begin
                    if (illegal || misaligned) begin
                        state_d       = ST_FAULT;
                        fault_d       = 1'b1;
                        fault_cause_d = illegal ? 2'd3 : 2'd0;
                        fault_addr_d  = req_addr;
                        result_d      = '0;
                    end else begin
                        state_d     = ST_BUSY;
                        bus_req_d   = 1'b1;
                        bus_we_d    = req_write;
                        bus_addr_d  = {req_addr[CPU_WIDTH-1:2], 2'b00};
                        bus_be_d    = be_calc;
                        bus_wdata_d = wdata_calc;
                        f3_d        = req_funct3;
                        addr_d      = req_addr;
                        cnt_d       = '0;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_err) begin
                    state_d       = ST_FAULT;
                    bus_req_d     = 1'b0;
                    fault_d       = 1'b1;
                    fault_cause_d = 2'd1;
                    fault_addr_d  = addr_q;
                    result_d      = '0;
                end else if (bus_ack) begin
                    state_d        = ST_DONE;
                    bus_req_d      = 1'b0;
                    result_valid_d = 1'b1;
                    result_d       = bus_we_q ? '0 : load_fmt;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = ST_FAULT;
                    bus_req_d     = 1'b0;
                    fault_d       = 1'b1;
                    fault_cause_d = 2'd2;
                    fault_addr_d  = addr_q;
                    result_d      = '0;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            bus_req_q      <= 1'b0;
            bus_we_q       <= 1'b0;
            bus_addr_q     <= '0;
            bus_be_q       <= '0;
            bus_wdata_q    <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            fault_q        <= 1'b0;
            fault_cause_q  <= '0;
            fault_addr_q   <= '0;
            f3_q           <= '0;
            addr_q         <= '0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            bus_req_q      <= bus_req_d;
            bus_we_q       <= bus_we_d;
            bus_addr_q     <= bus_addr_d;
            bus_be_q       <= bus_be_d;
            bus_wdata_q    <= bus_wdata_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            fault_q        <= fault_d;
            fault_cause_q  <= fault_cause_d;
            fault_addr_q   <= fault_addr_d;
            f3_q           <= f3_d;
            addr_q         <= addr_d;
            cnt_q          <= cnt_d;
        end
    end

    assign stall        = ((state_q == ST_IDLE) & req_active) | (state_q == ST_BUSY);
    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_be       = bus_be_q;
    assign bus_wdata    = bus_wdata_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign fault        = fault_q;
    assign fault_cause  = fault_cause_q;
    assign fault_addr   = fault_addr_q;

endmodule
